// File: rtl/caliptra_prim_subreg_hw_sched.sv
// Round-robin scheduler sharing one subregister's hardware update port among NumReq writers.
// Optional collision counter built when CALIPTRA_PRIM_SUBREG_HW_SCHED_COLL_CNT_EN is defined.
module caliptra_prim_subreg_hw_sched #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned StarveThr = 8,
    localparam int unsigned IdxW     = $clog2(NumReq)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sw_we_i,
    input  logic [NumReq-1:0]      req_i,
    input  logic [NumReq*DW-1:0]   req_data_i,
    output logic [NumReq-1:0]      gnt_o,
    output logic                   de_o,
    output logic [DW-1:0]          d_o,
    output logic                   starve_o,
    output logic [IdxW-1:0]        lock_idx_o
`ifdef CALIPTRA_PRIM_SUBREG_HW_SCHED_COLL_CNT_EN
    ,
    input  logic                   coll_clr_i,
    output logic [15:0]            coll_cnt_o
`endif
);

    localparam int unsigned SumW = IdxW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mode_e;

    mode_e           mode_q, mode_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [7:0]      blk_cnt_q, blk_cnt_d;
    logic            starve_q, starve_d;

    logic            win_vld;
    logic [IdxW-1:0] win_idx;
    logic            gnt_vld;
    logic [IdxW-1:0] gnt_idx;

    logic [DW-1:0]   data_arr [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign data_arr[g] = req_data_i[g*DW +: DW];
    end

    function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] v);
        if (v == IdxW'(NumReq - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // First requester at or above rr_ptr, wrapping modulo NumReq.
    always_comb begin
        logic [SumW-1:0] sum;
        logic [IdxW-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NumReq; i++) begin
            sum = {1'b0, rr_ptr_q} + SumW'(i);
            if (sum >= SumW'(NumReq)) begin
                sum = sum - SumW'(NumReq);
            end
            cand = sum[IdxW-1:0];
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        mode_d     = mode_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        blk_cnt_d  = blk_cnt_q;
        starve_d   = starve_q;
        gnt_vld    = 1'b0;
        gnt_idx    = win_idx;
        unique case (mode_q)
            IDLE: begin
                if (win_vld) begin
                    if (!sw_we_i) begin
                        gnt_vld  = 1'b1;
                        gnt_idx  = win_idx;
                        rr_ptr_d = inc_wrap(win_idx);
                    end else begin
                        // Software owns this cycle; park the winner until it lets go.
                        mode_d     = LOCKED;
                        lock_idx_d = win_idx;
                        blk_cnt_d  = 8'd1;
                        starve_d   = (StarveThr <= 1);
                    end
                end
            end
            LOCKED: begin
                if (!req_i[lock_idx_q]) begin
                    mode_d    = IDLE;
                    blk_cnt_d = 8'd0;
                    starve_d  = 1'b0;
                end else if (!sw_we_i) begin
                    gnt_vld   = 1'b1;
                    gnt_idx   = lock_idx_q;
                    rr_ptr_d  = inc_wrap(lock_idx_q);
                    mode_d    = IDLE;
                    blk_cnt_d = 8'd0;
                    starve_d  = 1'b0;
                end else begin
                    if (blk_cnt_q != 8'hFF) begin
                        blk_cnt_d = blk_cnt_q + 8'd1;
                    end
                    if (({1'b0, blk_cnt_q} + 9'd1) >= 9'(StarveThr)) begin
                        starve_d = 1'b1;
                    end
                end
            end
            default: mode_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            blk_cnt_q  <= 8'd0;
            starve_q   <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            blk_cnt_q  <= blk_cnt_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (gnt_vld) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    assign de_o       = gnt_vld;
    assign d_o        = gnt_vld ? data_arr[gnt_idx] : '0;
    assign starve_o   = starve_q;
    assign lock_idx_o = lock_idx_q;

`ifdef CALIPTRA_PRIM_SUBREG_HW_SCHED_COLL_CNT_EN
    logic [15:0] coll_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coll_cnt_q <= 16'd0;
        end else if (coll_clr_i) begin
            coll_cnt_q <= 16'd0;
        end else if ((|req_i) && sw_we_i && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign coll_cnt_o = coll_cnt_q;
`endif

    gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

endmodule
